// File: rtl/ram_arbiter_pkg.sv
// Shared core defines (reset polarity, pipeline hold flags) plus arbiter package.
// Build option: define RAM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
// Pure declarations: no latency, no backpressure.
`ifndef RAM_ARB_SHARED_DEFINES
`define RAM_ARB_SHARED_DEFINES
`define RST_ENABLE    1'b0
`define RST_DISABLE   1'b1
`define HOLD_FLAG_BUS 2:0
`define HOLD_NONE     3'b000
`define HOLD_PIPE     3'b011
`endif

package ram_arbiter_pkg;

  // Requester identity, used for rd_owner and last_grant
  localparam logic MASTER_M0 = 1'b0;
  localparam logic MASTER_M1 = 1'b1;

  // Width needed to hold 0..max_val inclusive
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ram_arb_prio.sv
// Combinational winner select for the RAM arbiter; policy set by RAM_ARB_RR_EN.
// Latency: 0 cycles (pure combinational).
// Backpressure: losers are simply not granted; they must hold their request.
module ram_arb_prio
  import ram_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = cnt_width(STARVE_MAX)
) (
  input  logic             m0_req,
  input  logic             m1_req,
  input  logic             lock_state,
`ifdef RAM_ARB_RR_EN
  input  logic             last_grant,
`else
  input  logic [CNT_W-1:0] starve_cnt,
`endif
  output logic [1:0]       gnt
);

  // One-hot grant: bit0 = m0, bit1 = m1
  always_comb begin
    gnt = 2'b00;
    if (lock_state) begin
      // Loader owns the RAM; the core is shut out
      gnt = {m1_req, 1'b0};
    end else if (m0_req && m1_req) begin
`ifdef RAM_ARB_RR_EN
      gnt = (last_grant == MASTER_M1) ? 2'b01 : 2'b10;
`else
      // Core wins unless the loader has waited long enough
      gnt = (starve_cnt == CNT_W'(STARVE_MAX)) ? 2'b10 : 2'b01;
`endif
    end else begin
      gnt = {m1_req, m0_req};
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single-port data RAM between core (m0) and loader (m1); build option RAM_ARB_RR_EN.
// Latency: grant 0 cycles, read data 1 cycle after grant.
// Backpressure: denied m0 raises hold_flag_o; denied requesters keep req/payload stable.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req_i,
  input  logic                 m0_we_i,
  input  logic [ADDR_W-1:0]    m0_addr_i,
  input  logic [DATA_W-1:0]    m0_wdata_i,
  output logic                 m0_gnt_o,
  output logic                 m0_rvalid_o,
  output logic [DATA_W-1:0]    m0_rdata_o,
  input  logic                 m1_req_i,
  input  logic                 m1_we_i,
  input  logic [ADDR_W-1:0]    m1_addr_i,
  input  logic [DATA_W-1:0]    m1_wdata_i,
  output logic                 m1_gnt_o,
  output logic                 m1_rvalid_o,
  output logic [DATA_W-1:0]    m1_rdata_o,
  input  logic                 m1_lock_i,
  output logic                 ram_we_o,
  output logic [ADDR_W-1:0]    ram_waddr_o,
  output logic [ADDR_W-1:0]    ram_raddr_o,
  output logic [DATA_W-1:0]    ram_wdata_o,
  input  logic [DATA_W-1:0]    ram_rdata_i,
  output logic [`HOLD_FLAG_BUS] hold_flag_o
);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_M1_LOCK = 1'b1;
  localparam int   CNT_W      = cnt_width(STARVE_MAX);

  logic       state, state_nxt;
  logic       rd_pend, rd_owner;
  logic       run;
  logic [1:0] gnt_raw, gnt;

  // While reset is held nothing is granted and no response is presented
  assign run = (rst == `RST_DISABLE);
  assign gnt = run ? gnt_raw : 2'b00;

`ifdef RAM_ARB_RR_EN
  logic last_grant;

  ram_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .m0_req     (m0_req_i),
    .m1_req     (m1_req_i),
    .lock_state (state == ST_M1_LOCK),
    .last_grant (last_grant),
    .gnt        (gnt_raw)
  );

  // Remember who was served last so the other side wins the next conflict
  always_ff @(posedge clk) begin
    if (rst == `RST_ENABLE)  last_grant <= MASTER_M1;
    else if (gnt[0])         last_grant <= MASTER_M0;
    else if (gnt[1])         last_grant <= MASTER_M1;
  end
`else
  logic [CNT_W-1:0] starve_cnt;

  ram_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .m0_req     (m0_req_i),
    .m1_req     (m1_req_i),
    .lock_state (state == ST_M1_LOCK),
    .starve_cnt (starve_cnt),
    .gnt        (gnt_raw)
  );

  // Count loader cycles lost to the core; saturate, clear on any loader grant
  always_ff @(posedge clk) begin
    if (rst == `RST_ENABLE)
      starve_cnt <= '0;
    else if (gnt[1])
      starve_cnt <= '0;
    else if ((state == ST_IDLE) && m1_req_i && (starve_cnt != CNT_W'(STARVE_MAX)))
      starve_cnt <= starve_cnt + CNT_W'(1);
  end
`endif

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  // Granted master drives the RAM; idle bus is all zeros
  always_comb begin
    ram_we_o    = 1'b0;
    ram_waddr_o = '0;
    ram_raddr_o = '0;
    ram_wdata_o = '0;
    if (gnt[0]) begin
      ram_we_o    = m0_we_i;
      ram_waddr_o = m0_addr_i;
      ram_raddr_o = m0_addr_i;
      ram_wdata_o = m0_wdata_i;
    end else if (gnt[1]) begin
      ram_we_o    = m1_we_i;
      ram_waddr_o = m1_addr_i;
      ram_raddr_o = m1_addr_i;
      ram_wdata_o = m1_wdata_i;
    end
  end

  // Lock is entered only through an actual loader grant and left as soon as lock drops
  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE) begin
      if (gnt[1] && m1_lock_i) state_nxt = ST_M1_LOCK;
    end else begin
      if (!m1_lock_i) state_nxt = ST_IDLE;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst == `RST_ENABLE) state <= ST_IDLE;
    else                    state <= state_nxt;
  end

  // Track the outstanding read so its data returns to the issuer next cycle
  always_ff @(posedge clk) begin
    if (rst == `RST_ENABLE) begin
      rd_pend  <= 1'b0;
      rd_owner <= MASTER_M0;
    end else begin
      rd_pend  <= (|gnt) && !ram_we_o;
      rd_owner <= gnt[1] ? MASTER_M1 : MASTER_M0;
    end
  end

  assign m0_rvalid_o = run && rd_pend && (rd_owner == MASTER_M0);
  assign m1_rvalid_o = run && rd_pend && (rd_owner == MASTER_M1);
  assign m0_rdata_o  = m0_rvalid_o ? ram_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? ram_rdata_i : '0;

  // Stall the core pipeline whenever its access is refused
  assign hold_flag_o = (run && m0_req_i && !gnt[0]) ? `HOLD_PIPE : `HOLD_NONE;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: per-cycle grant/hold/RAM-bus checks, read data via queues.
// Latency: expects read data exactly one cycle after grant.
// Backpressure: denied requesters are re-driven by the stimulus until granted.
module tb_ram_arbiter;

  localparam logic [2:0] H_NONE = 3'b000;
  localparam logic [2:0] H_PIPE = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i, m1_lock_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        ram_we_o;
  logic [31:0] ram_waddr_o, ram_raddr_o, ram_wdata_o;
  logic [31:0] ram_rdata_i = '0;
  logic [2:0]  hold_flag_o;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] q0[$], q1[$];
  int          q0c[$], q1c[$];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .m1_lock_i(m1_lock_i),
    .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o), .ram_raddr_o(ram_raddr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .hold_flag_o(hold_flag_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // RAM model: one-cycle read latency, write at the clock edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ram_rdata_i <= mdl_rd(ram_raddr_o);
    if (ram_we_o) mem[ram_waddr_o] = ram_wdata_o;
  end

  // Response monitor: pop expected read data when the DUT presents it
  always @(negedge clk) begin
    if (m0_rvalid_o) begin
      if (q0.size() == 0) check("m0_rvalid_unexpected", m0_rvalid_o, 0);
      else begin
        check("m0_rdata", m0_rdata_o, q0.pop_front());
        void'(q0c.pop_front());
      end
    end else begin
      check("m0_rdata_idle", m0_rdata_o, 0);
      if (q0.size() > 0 && q0c[0] < cyc) begin
        check("m0_rvalid_missing", m0_rvalid_o, 1);
        void'(q0.pop_front());
        void'(q0c.pop_front());
      end
    end
    if (m1_rvalid_o) begin
      if (q1.size() == 0) check("m1_rvalid_unexpected", m1_rvalid_o, 0);
      else begin
        check("m1_rdata", m1_rdata_o, q1.pop_front());
        void'(q1c.pop_front());
      end
    end else begin
      check("m1_rdata_idle", m1_rdata_o, 0);
      if (q1.size() > 0 && q1c[0] < cyc) begin
        check("m1_rvalid_missing", m1_rvalid_o, 1);
        void'(q1.pop_front());
        void'(q1c.pop_front());
      end
    end
  end

  // One clock cycle of stimulus; entered and left just after a rising edge
  task automatic step(input string tag,
                      input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic lk, input logic eg0, input logic eg1);
    m0_req_i = r0; m0_we_i = w0; m0_addr_i = a0; m0_wdata_i = d0;
    m1_req_i = r1; m1_we_i = w1; m1_addr_i = a1; m1_wdata_i = d1;
    m1_lock_i = lk;
    @(negedge clk);
    check({tag, ".m0_gnt"}, m0_gnt_o, eg0);
    check({tag, ".m1_gnt"}, m1_gnt_o, eg1);
    check({tag, ".hold"}, hold_flag_o, (r0 && !eg0) ? H_PIPE : H_NONE);
    check({tag, ".ram_we"}, ram_we_o, (eg0 && w0) || (eg1 && w1));
    if (eg0 || eg1) check({tag, ".raddr"}, ram_raddr_o, eg0 ? a0 : a1);
    if ((eg0 && w0) || (eg1 && w1)) begin
      check({tag, ".waddr"}, ram_waddr_o, eg0 ? a0 : a1);
      check({tag, ".wdata"}, ram_wdata_o, eg0 ? d0 : d1);
    end
    if (eg0 && !w0) begin q0.push_back(mdl_rd(a0)); q0c.push_back(cyc); end
    if (eg1 && !w1) begin q1.push_back(mdl_rd(a1)); q1c.push_back(cyc); end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Hold reset for one edge; outstanding reads are expected to be dropped
  task automatic do_reset(input logic lk);
    rst = 1'b0;
    m0_req_i = 0; m1_req_i = 0; m1_lock_i = lk;
    q0.delete(); q0c.delete(); q1.delete(); q1c.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst.m0_rvalid", m0_rvalid_o, 0);
    check("post_rst.m1_rvalid", m1_rvalid_o, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    m0_req_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_i = 0; m1_wdata_i = 0; m1_lock_i = 0;
    mem[32'h10] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.m0_gnt", m0_gnt_o, 0);
    check("rst.m1_gnt", m1_gnt_o, 0);
    check("rst.m0_rvalid", m0_rvalid_o, 0);
    check("rst.m1_rvalid", m1_rvalid_o, 0);
    check("rst.ram_we", ram_we_o, 0);
    check("rst.hold", hold_flag_o, H_NONE);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single core read, then back-to-back core reads
    step("rd10", 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0);
    idle("rd10_ret");
    for (int i = 0; i < 3; i++)
      step("b2b", 1, 0, 32'h100 + 32'(4 * i), 0, 0, 0, 0, 0, 0, 1, 0);
    idle("b2b_ret");

    // Loader write then read-back of the same word
    step("m1_wr", 0, 0, 0, 0, 1, 1, 32'h20, 32'h1234_5678, 0, 0, 1);
    step("m1_rd", 0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 0, 1);
    idle("m1_rd_ret");

    // Continuous conflict
`ifdef RAM_ARB_RR_EN
    for (int i = 0; i < 4; i++)
      step("rr", 1, 0, 32'h200 + 32'(4 * i), 0, 1, 0, 32'h300 + 32'(4 * i), 0, 0,
           (i % 2) == 0, (i % 2) == 1);
`else
    for (int i = 0; i < 10; i++)
      step("starve", 1, 0, 32'h200 + 32'(4 * i), 0, 1, 0, 32'h300, 0, 0, i != 8, i == 8);
`endif
    idle("conflict_ret");

    // Core read then loader read on consecutive cycles: data routed to each issuer
    step("split0", 1, 0, 32'h400, 0, 0, 0, 0, 0, 0, 1, 0);
    step("split1", 0, 0, 0, 0, 1, 0, 32'h10, 0, 0, 0, 1);
    idle("split_ret");

    // Locked loader burst shuts the core out until the cycle after lock drops
    step("lock0", 0, 0, 0, 0, 1, 1, 32'h20, 32'hA0A0_0001, 1, 0, 1);
    step("lock1", 1, 0, 32'h20, 0, 1, 1, 32'h24, 32'hA0A0_0002, 1, 0, 1);
    step("lock2", 1, 0, 32'h20, 0, 1, 1, 32'h28, 32'hA0A0_0003, 1, 0, 1);
    step("lock_drop", 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0);
    step("lock_after", 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0);
    idle("lock_ret");

    // Lock without a loader request has no effect
    step("lk_noreq0", 1, 0, 32'h24, 0, 0, 0, 0, 0, 1, 1, 0);
    step("lk_noreq1", 1, 0, 32'h28, 0, 0, 0, 0, 0, 1, 1, 0);
    idle("lk_noreq_ret");

    // Reset while a core read is outstanding
    step("rst_rd", 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0);
    do_reset(1'b0);
    step("rst_rd_after", 1, 0, 32'h30, 0, 0, 0, 0, 0, 0, 1, 0);
    idle("rst_rd_ret");

    // Reset while locked must return to IDLE even with lock still high
    step("rlk0", 0, 0, 0, 0, 1, 0, 32'h40, 0, 1, 0, 1);
    step("rlk1", 1, 0, 32'h44, 0, 1, 0, 32'h48, 0, 1, 0, 1);
    do_reset(1'b1);
    step("rlk_idle", 1, 0, 32'h44, 0, 0, 0, 0, 0, 1, 1, 0);
    idle("rlk_ret0");
    idle("rlk_ret1");

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates the single-port data RAM between two requesters: the core's execute-stage load/store port (m0) and a debug/program-loader port (m1). Each cycle it grants at most one access. It routes the RAM's one-cycle-latency read data back to the requester that issued the read. While m0 is blocked, it raises a pipeline hold toward pc_reg/if_id/id_ex. It sits between ex/loader and ram in the core top level.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 8, consecutive denied m1 cycles before m1 is forced to win once (fixed-priority mode only)

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- m0_req_i  in  1  core access request
- m0_we_i  in  1  1 = write, 0 = read
- m0_addr_i  in  ADDR_W  byte address
- m0_wdata_i  in  DATA_W  write data
- m0_gnt_o  out  1  access accepted this cycle
- m0_rvalid_o  out  1  read data valid
- m0_rdata_o  out  DATA_W  read data
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o: same as m0, for the loader
- m1_lock_i  in  1  loader requests exclusive ownership across accesses
- ram_we_o  out  1  RAM write enable
- ram_waddr_o  out  ADDR_W  RAM write address
- ram_raddr_o  out  ADDR_W  RAM read address
- ram_wdata_o  out  DATA_W  RAM write data
- ram_rdata_i  in  DATA_W  RAM read data, valid one cycle after raddr
- hold_flag_o  out  3  `HOLD_NONE, or `HOLD_PIPE while m0 is stalled

## Operation
- FSM states: IDLE, M1_LOCK.
- IDLE with both requesting: the winner is chosen by policy (see Configuration). With a single requester, that requester wins.
- M1_LOCK: only m1 may be granted. m0 is always denied.
- IDLE → M1_LOCK: at the edge where m1 is granted and m1_lock_i=1.
- M1_LOCK → IDLE: at the first edge where m1_lock_i=0. The m1 access granted in that cycle still completes.
- Granted master drives the RAM combinationally:
  - ram_we_o = gnt & we
  - ram_waddr_o = ram_raddr_o = addr
  - ram_wdata_o = wdata
- With no grant, ram_we_o=0 and the address/data outputs are 0.
- A granted read sets the registers rd_pend=1 and rd_owner=master. The next cycle, that master's rvalid_o=1 and its rdata_o=ram_rdata_i. The other master sees rvalid_o=0 and rdata_o=0.
- Writes give no response beyond gnt.
- hold_flag_o = `HOLD_PIPE when m0_req_i & ~m0_gnt_o; otherwise `HOLD_NONE. It is combinational.
- A denied requester keeps its req and payload stable until granted. The arbiter does not latch denied requests.

## Timing
- Grant: 0 cycles (combinational from req, state and priority registers).
- Read latency: 1 cycle from gnt to rvalid. Back-to-back reads are accepted every cycle.
- A read granted in cycle t and a different master's grant in cycle t+1: rvalid for t's owner is still delivered in t+1.
- Reset values, after reset is sampled low:
  - Outputs: all gnt/rvalid = 0; rdata = 0; ram_we_o = 0; hold_flag_o = `HOLD_NONE.
  - Internal: state = IDLE; rd_pend = 0; last_grant = m1; starve_cnt = 0.
- Reset mid-read: the pending rvalid is dropped.
- Reset during M1_LOCK: return to IDLE.
- m1_lock_i high with m1_req_i low in IDLE: no effect.

## Configuration
- RAM_ARB_RR_EN defined: round-robin. On conflict in IDLE, the master not in last_grant wins. last_grant updates on every grant. starve_cnt is not built.
- RAM_ARB_RR_EN undefined: fixed priority with m0 winning.
  - starve_cnt increments each cycle m1 is requesting and denied in IDLE. It saturates at STARVE_MAX.
  - When starve_cnt == STARVE_MAX, m1 wins the next conflict, then the counter clears.
  - Any m1 grant also clears the counter.

## Structure
- `HOLD_NONE, `HOLD_PIPE and `HOLD_FLAG_BUS live in the shared defines.v, alongside the existing reset-polarity constants.
- FSM state encodings are local parameters.
- One sub-module, ram_arb_prio: combinational winner select (inputs: reqs, state, last_grant/starve_cnt; output: one-hot grant), swapped by RAM_ARB_RR_EN.
- Read-return registers and the FSM stay in ram_arbiter.

## Test plan
- m0 only, read 0x10, RAM returns 0xDEADBEEF → m0_gnt_o=1 in cycle t; m0_rvalid_o=1 with m0_rdata_o=0xDEADBEEF in t+1; hold_flag_o=`HOLD_NONE throughout.
- m0 and m1 both request in every cycle for 4 cycles, RR build → grants alternate m0, m1, m0, m1. hold_flag_o=`HOLD_PIPE exactly in the m1-granted cycles.
- Fixed build, both request continuously, STARVE_MAX=8 → m0 granted 8 cycles, m1 granted in the 9th, then m0 again.
- m1 write 0x20 with m1_lock_i=1 for 3 cycles while m0 requests → M1_LOCK held; m0 denied and `HOLD_PIPE for those cycles; m0 granted the cycle after lock drops.
- m0 read granted at t, m1 read granted at t+1 → t+1: m0_rvalid_o=1, m1_rvalid_o=0; t+2: m1_rvalid_o=1 with the correct data.
- Reset asserted the cycle after an m0 read grant → m0_rvalid_o=0 and state IDLE after the reset edge.
